croma_config_fsm: RTL and testbench
===================================

// Module: croma_config_fsm
// PURPOSE
//   Button-driven colour configuration controller for the VGA text display.
//   - Conditions raw Up/Down/TC/Lp inputs: 2-FF synchroniser, debounce, rising-edge pulse.
//   - Edits shadow registers for letter colour, background colour and tone.
//   - Commits shadow values to ColorL/ColorP/ton only while vblank is high,
//     so the output stage never sees a mid-frame colour change.
// PARAMETERS
//   DEB_CYCLES  250000  stable cycles before a debounced level changes (10 ms @ 25 MHz)
//   TON_STEP    8       ton increment/decrement per Up/Down pulse
//   REP_DELAY   12500000  hold cycles before auto-repeat starts (AUTOREPEAT_EN only)
//   REP_PERIOD  2500000   cycles between repeat pulses (AUTOREPEAT_EN only)
// PORTS
//   Clk      in   1  pixel clock
//   reset    in   1  synchronous reset, active-low
//   Up       in   1  raw button: increase tone
//   Down     in   1  raw button: decrease tone
//   TC       in   1  raw button: toggle edit target (0 letter, 1 background)
//   Lp       in   1  raw button: step colour index of current target
//   vblank   in   1  high during vertical blanking (from vertical counter)
//   ColorL   out  3  committed letter colour index
//   ColorP   out  3  committed background colour index
//   ton      out  8  committed tone
//   sel      out  1  current edit target
//   pending  out  1  shadow differs from committed outputs; commit awaited
// BEHAVIOUR
//   - Reset (reset==0 at posedge Clk): ColorL=7, ColorP=0, ton=128, sel=0, pending=0.
//     Shadows take the same values; FSM=IDLE; sync FFs, debounce counters and
//     debounced levels cleared. Reset mid-WAIT_VB discards all uncommitted edits.
//   - Debounce, per button: counter counts while synced input != debounced level
//     and clears otherwise. When the count reaches DEB_CYCLES-1 the level flips.
//     A 0->1 flip produces a 1-cycle pulse.
//   - One pulse is processed per cycle, priority TC > Lp > Up > Down.
//     Lower-priority pulses arriving in the same cycle are dropped.
//   - TC: sel <= ~sel.
//   - Lp: shadow colour of target sel <= (idx+1) mod 8.
//     If the result equals the other target's shadow colour, skip to (idx+2) mod 8.
//   - Up: shadow ton <= min(ton+TON_STEP, 255). Down: max(ton-TON_STEP, 0).
//     Compute 9-bit, then saturate.
//   - Any Lp/Up/Down pulse sets pending, even if the value ends up unchanged.
//     TC alone does not set pending.
//   - FSM:
//     IDLE    -> WAIT_VB  on a pending-setting pulse.
//     WAIT_VB -> COMMIT   in the cycle vblank is sampled high. Edits are still accepted here.
//     COMMIT  : one cycle. Copies shadows to outputs, clears pending, -> IDLE.
//               A pulse in this cycle updates the shadow, keeps pending=1 and goes to WAIT_VB.
//   - Latency: debounced edge -> shadow update 1 cycle later.
//     Outputs update on the clock after COMMIT is entered.
//     With vblank already high, pulse -> outputs updated in 3 cycles.
//   - Outputs are registered and change only in COMMIT or on reset.
// CONFIGURATION
//   AUTOREPEAT_EN defined:
//     - Up or Down held with debounced level 1 for REP_DELAY cycles produces one extra pulse.
//     - Further pulses follow every REP_PERIOD cycles until release.
//     - Repeat pulses obey the same priority and saturation rules.
//   AUTOREPEAT_EN undefined:
//     - One pulse per press; repeat counters and REP_* parameters are unused.
// TESTING  (DEB_CYCLES=4, TON_STEP=8, REP_DELAY=20, REP_PERIOD=5)
//   1. reset low 2 cycles -> ColorL=7, ColorP=0, ton=128, sel=0, pending=0.
//   2. Up high 10 cycles, vblank=0 -> pending=1, ton stays 128.
//      Then vblank=1 -> ton=136 within 2 cycles, pending=0.
//   3. Up high 2 cycles then low (glitch) -> no pulse, pending=0, ton=128.
//   4. Shadow ton=248, two Up presses, commit -> ton=255.
//      From ton=0, Down press, commit -> ton=0, pending cleared.
//   5. sel=0, ColorL=7, ColorP=0, Lp press, commit -> ColorL=1 (0 skipped).
//      Then TC + Lp, commit -> sel=1, ColorP=2 (1 skipped).
//   6. Up press with vblank=0, reset asserted while in WAIT_VB, then vblank=1
//      -> ton=128, pending=0.
//      With AUTOREPEAT_EN: Up held 40 cycles -> 5 pulses total (1 press + 4 repeats),
//      committed ton=168.

Source files
------------

// File: rtl/croma_config_fsm.sv
// croma_config_fsm
//   Button-driven colour configuration controller for the VGA text display.
//   Raw buttons are synchronised, debounced and turned into rising-edge pulses.
//   Pulses edit shadow copies of letter colour, background colour and tone.
//   Shadows are copied to the outputs only while vblank is high, so the
//   output stage never sees a colour change in the middle of a frame.
//
//   Optional feature macro: AUTOREPEAT_EN
//     defined   : a held Up/Down button produces repeat pulses, the first
//                 after REP_DELAY cycles and then every REP_PERIOD cycles.
//     undefined : one pulse per press; REP_* parameters have no effect.
//
// Ports
//   clk_i       pixel clock
//   reset_ni    synchronous reset, active-low
//   up_i        raw button: increase tone
//   down_i      raw button: decrease tone
//   tc_i        raw button: toggle edit target (0 letter, 1 background)
//   lp_i        raw button: step colour index of current target
//   vblank_i    high during vertical blanking
//   color_l_o   committed letter colour index
//   color_p_o   committed background colour index
//   ton_o       committed tone
//   sel_o       current edit target
//   pending_o   shadow edits waiting for a commit
//
// State      | meaning
// S_IDLE     | outputs match shadows, nothing to commit
// S_WAIT_VB  | edits pending, waiting for vblank
// S_COMMIT   | one cycle: shadows copied to outputs

module croma_config_fsm #(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned TON_STEP   = 8,
    parameter int unsigned REP_DELAY  = 12500000,
    parameter int unsigned REP_PERIOD = 2500000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       tc_i,
    input  logic       lp_i,
    input  logic       vblank_i,
    output logic [2:0] color_l_o,
    output logic [2:0] color_p_o,
    output logic [7:0] ton_o,
    output logic       sel_o,
    output logic       pending_o
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
    localparam logic [8:0]  STEP9 = 9'(TON_STEP);

    if (DEB_CYCLES < 2 || TON_STEP == 0 || TON_STEP > 255 ||
        REP_DELAY == 0 || REP_PERIOD == 0) begin : g_bad_param
        $error("croma_config_fsm: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VB = 2'd1,
        S_COMMIT  = 2'd2
    } state_e;

    // Button vector order: {tc, lp, up, down}, which is also the priority order.
    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync2_q, level_q, pulse_q;
    logic [DEB_W-1:0] deb_cnt_q [4];
    logic [3:0]       evt;

    assign btn_raw = {tc_i, lp_i, up_i, down_i};

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                pulse_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt_q[i] <= '0;
                    level_q[i]   <= sync2_q[i];
                    pulse_q[i]   <= sync2_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REP_DELAY + REP_PERIOD);

    logic [REP_W-1:0] rep_cnt_q [2];
    logic [1:0]       rep_pulse_q;

    // Down-counter per Up/Down button. It stays loaded with the initial delay
    // until the button is held (debounced level and synced input both high),
    // so releasing the button stops repeats immediately.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rep_pulse_q <= '0;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= REP_W'(REP_DELAY - 1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_pulse_q[i] <= 1'b0;
                if (!(level_q[i] && sync2_q[i])) begin
                    rep_cnt_q[i] <= REP_W'(REP_DELAY - 1);
                end else if (rep_cnt_q[i] == '0) begin
                    rep_pulse_q[i] <= 1'b1;
                    rep_cnt_q[i]   <= REP_W'(REP_PERIOD - 1);
                end else begin
                    rep_cnt_q[i] <= rep_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign evt = {pulse_q[3:2], pulse_q[1:0] | rep_pulse_q};
`else
    assign evt = pulse_q;
`endif

    state_e     state_q, state_d;
    logic [2:0] shad_l_q, shad_l_d, shad_p_q, shad_p_d;
    logic [7:0] shad_ton_q, shad_ton_d;
    logic [2:0] color_l_q, color_l_d, color_p_q, color_p_d;
    logic [7:0] ton_q, ton_d;
    logic       sel_q, sel_d, pending_q, pending_d;
    logic       edit;
    logic [2:0] lp_next;
    logic [8:0] ton_sum;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            shad_l_q   <= 3'd7;
            shad_p_q   <= 3'd0;
            shad_ton_q <= 8'd128;
            color_l_q  <= 3'd7;
            color_p_q  <= 3'd0;
            ton_q      <= 8'd128;
            sel_q      <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shad_l_q   <= shad_l_d;
            shad_p_q   <= shad_p_d;
            shad_ton_q <= shad_ton_d;
            color_l_q  <= color_l_d;
            color_p_q  <= color_p_d;
            ton_q      <= ton_d;
            sel_q      <= sel_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shad_l_d   = shad_l_q;
        shad_p_d   = shad_p_q;
        shad_ton_d = shad_ton_q;
        color_l_d  = color_l_q;
        color_p_d  = color_p_q;
        ton_d      = ton_q;
        sel_d      = sel_q;
        pending_d  = pending_q;
        edit       = 1'b0;
        lp_next    = '0;
        ton_sum    = '0;

        // Only the highest-priority pulse of a cycle is acted on.
        if (evt[3]) begin
            sel_d = ~sel_q;
        end else if (evt[2]) begin
            edit = 1'b1;
            // Step the colour index, skipping the other target's colour so
            // letters never become invisible against the background.
            if (sel_q) begin
                lp_next = shad_p_q + 3'd1;
                if (lp_next == shad_l_q) lp_next = shad_p_q + 3'd2;
                shad_p_d = lp_next;
            end else begin
                lp_next = shad_l_q + 3'd1;
                if (lp_next == shad_p_q) lp_next = shad_l_q + 3'd2;
                shad_l_d = lp_next;
            end
        end else if (evt[1]) begin
            edit       = 1'b1;
            ton_sum    = {1'b0, shad_ton_q} + STEP9;
            shad_ton_d = ton_sum[8] ? 8'hFF : ton_sum[7:0];
        end else if (evt[0]) begin
            edit       = 1'b1;
            ton_sum    = {1'b0, shad_ton_q} - STEP9;
            shad_ton_d = ton_sum[8] ? 8'h00 : ton_sum[7:0];
        end

        if (edit) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (edit) state_d = S_WAIT_VB;
            end
            S_WAIT_VB: begin
                if (vblank_i) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                color_l_d = shad_l_q;
                color_p_d = shad_p_q;
                ton_d     = shad_ton_q;
                pending_d = edit;
                state_d   = edit ? S_WAIT_VB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign color_l_o = color_l_q;
    assign color_p_o = color_p_q;
    assign ton_o     = ton_q;
    assign sel_o     = sel_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_croma_config_fsm.sv
module tb_croma_config_fsm;

    localparam int DEB = 4;
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       reset_n, up, dn, tc, lp, vblank;
    logic [2:0] color_l_o, color_p_o;
    logic [7:0] ton_o;
    logic       sel_o, pending_o;

    always #5 clk = ~clk;

    croma_config_fsm #(
        .DEB_CYCLES(DEB),
        .TON_STEP  (STEP),
        .REP_DELAY (20),
        .REP_PERIOD(5)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .up_i     (up),
        .down_i   (dn),
        .tc_i     (tc),
        .lp_i     (lp),
        .vblank_i (vblank),
        .color_l_o(color_l_o),
        .color_p_o(color_p_o),
        .ton_o    (ton_o),
        .sel_o    (sel_o),
        .pending_o(pending_o)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int cl;
        int cp;
        int ton;
        int sel;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: shadow values, edit target, pending flag, committed values.
    int m_l, m_p, m_ton, m_sel, m_pend;
    int c_l, c_p, c_ton;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_l = 7; m_p = 0; m_ton = 128; m_sel = 0; m_pend = 0;
        c_l = 7; c_p = 0; c_ton = 128;
    endtask

    function automatic int step_colour(input int idx, input int other);
        int n;
        n = (idx + 1) % 8;
        if (n == other) n = (idx + 2) % 8;
        return n;
    endfunction

    // mask bits: 3 TC, 2 Lp, 1 Up, 0 Down; highest set bit wins.
    task automatic model_press(input int mask);
        if (mask[3]) begin
            m_sel = 1 - m_sel;
        end else if (mask[2]) begin
            if (m_sel == 1) m_p = step_colour(m_p, m_l);
            else            m_l = step_colour(m_l, m_p);
            m_pend = 1;
        end else if (mask[1]) begin
            m_ton = (m_ton + STEP > 255) ? 255 : m_ton + STEP;
            m_pend = 1;
        end else if (mask[0]) begin
            m_ton = (m_ton - STEP < 0) ? 0 : m_ton - STEP;
            m_pend = 1;
        end
    endtask

    task automatic model_commit();
        c_l = m_l; c_p = m_p; c_ton = m_ton; m_pend = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.cl = m_l; e.cp = m_p; e.ton = m_ton; e.sel = m_sel;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic press(input int mask, input int hold, input int gap);
        tc = mask[3]; lp = mask[2]; up = mask[1]; dn = mask[0];
        repeat (hold) @(negedge clk);
        tc = 1'b0; lp = 1'b0; up = 1'b0; dn = 1'b0;
        repeat (gap) @(negedge clk);
        model_press(mask);
    endtask

    task automatic do_commit();
        if (m_pend != 0) push_expected();
        vblank = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10 && pending_o; k++) @(negedge clk);
        check("commit_pending_clear", pending_o, 0);
        vblank = 1'b0;
        @(negedge clk);
        model_commit();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Monitor: a falling pending flag marks a commit; any other output change
    // outside reset is an error.
    initial begin
        exp_t e;
        logic       prev_pend;
        logic [2:0] pl, pp;
        logic [7:0] pt;
        prev_pend = 1'b0; pl = 3'd7; pp = 3'd0; pt = 8'd128;
        forever begin
            @(posedge clk);
            #2;
            if (reset_n === 1'b1) begin
                if (prev_pend && !pending_o) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_commit: no expectation queued at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_color_l", color_l_o, e.cl);
                        check("commit_color_p", color_p_o, e.cp);
                        check("commit_ton", ton_o, e.ton);
                        check("commit_sel", sel_o, e.sel);
                    end
                end else if (color_l_o !== pl || color_p_o !== pp || ton_o !== pt) begin
                    n_vec++; n_err++;
                    $display("FAIL output_change: got l=%0d p=%0d ton=%0d, required l=%0d p=%0d ton=%0d (no commit) at %0t",
                             color_l_o, color_p_o, ton_o, pl, pp, pt, $time);
                end
            end
            prev_pend = pending_o;
            pl = color_l_o; pp = color_p_o; pt = ton_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mask, hold, gap;
        reset_n = 1'b0; up = 1'b0; dn = 1'b0; tc = 1'b0; lp = 1'b0; vblank = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("reset_color_l", color_l_o, 7);
        check("reset_color_p", color_p_o, 0);
        check("reset_ton", ton_o, 128);
        check("reset_sel", sel_o, 0);
        check("reset_pending", pending_o, 0);

        // Up held 10 cycles with vblank low: pending, outputs untouched.
        press(2, 10, 8);
        check("wait_vb_pending", pending_o, 1);
        check("wait_vb_ton", ton_o, 128);
        push_expected();
        vblank = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("commit_latency_ton", ton_o, 136);
        check("commit_latency_pending", pending_o, 0);
        @(negedge clk);
        vblank = 1'b0;
        model_commit();

        // Glitch one cycle shorter than the debounce window: ignored.
        up = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        up = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_pending", pending_o, 0);
        check("glitch_ton", ton_o, c_ton);

        // Tone saturation at both ends.
        while (m_ton < 248) press(2, 6, 8);
        press(2, 6, 8);
        press(2, 6, 8);
        do_commit();
        check("sat_high_ton", ton_o, 255);
        while (m_ton > 0) press(1, 6, 8);
        do_commit();
        check("sat_low_ton", ton_o, 0);
        press(1, 6, 8);
        do_commit();
        check("sat_low_again_ton", ton_o, 0);
        check("sat_low_again_pending", pending_o, 0);

        // Colour stepping skips the other target's colour.
        apply_reset();
        press(4, 6, 8);
        do_commit();
        check("lp_letter_skip", color_l_o, 1);
        press(8, 6, 8);
        press(4, 6, 8);
        do_commit();
        check("tc_sel", sel_o, 1);
        check("lp_back_skip", color_p_o, 2);

        // Reset while waiting for vblank discards the edit.
        apply_reset();
        press(2, 6, 8);
        check("pre_reset_pending", pending_o, 1);
        apply_reset();
        vblank = 1'b1;
        repeat (5) @(negedge clk);
        vblank = 1'b0;
        check("reset_discard_ton", ton_o, 128);
        check("reset_discard_pending", pending_o, 0);

`ifdef AUTOREPEAT_EN
        // Held Up: 1 press pulse plus 4 repeats.
        up = 1'b1;
        repeat (40) @(negedge clk);
        up = 1'b0;
        repeat (12) @(negedge clk);
        for (int r = 0; r < 5; r++) model_press(2);
        do_commit();
        check("autorepeat_ton", ton_o, 168);
`endif

        // Randomised edit bursts, occasionally with two buttons pressed together.
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 4);
            for (int p = 0; p < n; p++) begin
                mask = 1 << $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) mask = mask | (1 << $urandom_range(0, 3));
                hold = $urandom_range(5, 9);
                gap  = $urandom_range(8, 12);
                press(mask, hold, gap);
            end
            do_commit();
            check("rand_sel", sel_o, m_sel);
            check("rand_ton", ton_o, c_ton);
        end

        repeat (5) @(negedge clk);
        check("leftover_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
